// File: rtl/scan_seq_if.sv
// Raster scan sequencer bus: frame control in,
// address beats out with a valid/ready handshake.
interface scan_seq_if #(
  parameter int COLS = 40,
  parameter int ROWS = 30
);
  localparam int ADDR_W =
    ($clog2(COLS*ROWS) < 1) ? 1 : $clog2(COLS*ROWS);
  localparam int CW =
    ($clog2(COLS) < 1) ? 1 : $clog2(COLS);
  localparam int RW =
    ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS);

  logic              start;
  logic              abort;
  logic              ready;
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              last;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, ready,
    input  valid, addr, col, row,
    input  last, busy, done
  );

  modport slave (
    input  start, abort, ready,
    output valid, addr, col, row,
    output last, busy, done
  );
endinterface

// File: rtl/scan_seq_ctrl.sv
// Frame scan sequencer: walks col/row/addr
// one beat per accepted handshake.
module scan_seq_ctrl #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input logic       clk,
  input logic       rst,
  scan_seq_if.slave bus
);
  localparam int ADDR_W =
    ($clog2(COLS*ROWS) < 1) ? 1 : $clog2(COLS*ROWS);
  localparam int CW =
    ($clog2(COLS) < 1) ? 1 : $clog2(COLS);
  localparam int RW =
    ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] COL_MAX = CW'(COLS-1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS-1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic run, at_end, xfer;

  assign run    = (state_q == S_RUN);
  assign at_end = (col_q == COL_MAX) && (row_q == ROW_MAX);
  assign xfer   = run && bus.ready;

  // Next-state and counter advance; final beat saturates.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      S_RUN: begin
        if (xfer && !at_end) begin
          addr_d = addr_q + ADDR_W'(1);
          if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (xfer && at_end) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.valid = run;
  assign bus.last  = run && at_end;
  assign bus.busy  = run || (state_q == S_DONE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.addr  = addr_q;
  assign bus.col   = col_q;
  assign bus.row   = row_q;
endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl with a
// 4x3 frame; checks on the falling edge.
module tb_scan_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   miscmp = 0;

  scan_seq_if #(.COLS(4), .ROWS(3)) bus();

  scan_seq_ctrl #(.COLS(4), .ROWS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ready = 1'b0;
    #1;
    vec++;
    if ({bus.valid, bus.last, bus.busy, bus.done} !== 4'b0 ||
        bus.addr !== 4'd0 || bus.col !== 2'd0 ||
        bus.row !== 2'd0) begin
      miscmp++;
      $display("FAIL reset: v%b l%b b%b d%b a%0d want all 0",
               bus.valid, bus.last, bus.busy, bus.done, bus.addr);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    vec++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      miscmp++;
      $display("FAIL idle_after_reset: busy=%b valid=%b want 0",
               bus.busy, bus.valid);
    end
  endtask

  task automatic test_full_frame();
    bus.start = 1'b1;
    bus.ready = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      vec++;
      if (bus.valid !== 1'b1 || bus.addr !== 4'(i) ||
          bus.col !== 2'(i % 4) || bus.row !== 2'(i / 4) ||
          bus.last !== (i == 11)) begin
        miscmp++;
        $display("FAIL frame_beat%0d: v%b a%0d c%0d r%0d l%b",
                 i, bus.valid, bus.addr, bus.col, bus.row,
                 bus.last);
      end
      tick();
    end
    vec++;
    if (bus.done !== 1'b1 || bus.valid !== 1'b0 ||
        bus.busy !== 1'b1) begin
      miscmp++;
      $display("FAIL frame_done: d%b v%b b%b want 1 0 1",
               bus.done, bus.valid, bus.busy);
    end
    tick();
    vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscmp++;
      $display("FAIL frame_idle: d%b b%b want 0 0",
               bus.done, bus.busy);
    end
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    int exp_a;
    int k;
    pat = 4'b1001;
    exp_a = 0;
    k = 0;
    bus.start = 1'b1;
    bus.ready = 1'b0;
    tick();
    bus.start = 1'b0;
    while (exp_a < 12 && k < 100) begin
      vec++;
      if (bus.valid !== 1'b1 || bus.addr !== 4'(exp_a) ||
          bus.col !== 2'(exp_a % 4) ||
          bus.row !== 2'(exp_a / 4)) begin
        miscmp++;
        $display("FAIL stall_k%0d: v%b a%0d c%0d r%0d want a%0d",
                 k, bus.valid, bus.addr, bus.col, bus.row, exp_a);
      end
      bus.ready = pat[3 - (k % 4)];
      tick();
      if (bus.ready) exp_a++;
      k++;
    end
    bus.ready = 1'b0;
    vec++;
    if (exp_a != 12 || bus.done !== 1'b1) begin
      miscmp++;
      $display("FAIL stall_done: beats=%0d done=%b want 12 1",
               exp_a, bus.done);
    end
    tick();
  endtask

  task automatic test_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    vec++;
    if (bus.busy !== 1'b0) begin
      miscmp++;
      $display("FAIL abort_in_idle: busy=%b want 0", bus.busy);
    end
    bus.start = 1'b1;
    bus.ready = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    vec++;
    if (bus.addr !== 4'd5 || bus.valid !== 1'b1) begin
      miscmp++;
      $display("FAIL abort_pre: a%0d v%b want 5 1",
               bus.addr, bus.valid);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    vec++;
    if (bus.valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.busy !== 1'b0) begin
      miscmp++;
      $display("FAIL abort_post: v%b d%b b%b want 0 0 0",
               bus.valid, bus.done, bus.busy);
    end
    tick();
    vec++;
    if (bus.valid !== 1'b0 || bus.done !== 1'b0) begin
      miscmp++;
      $display("FAIL abort_no_queue: v%b d%b want 0 0",
               bus.valid, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1;
    bus.ready = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      vec++;
      if (bus.valid !== 1'b1 || bus.addr !== 4'(i)) begin
        miscmp++;
        $display("FAIL b2b_a%0d: v%b a%0d", i, bus.valid,
                 bus.addr);
      end
      tick();
    end
    vec++;
    if (bus.done !== 1'b1) begin
      miscmp++;
      $display("FAIL b2b_done: done=%b want 1", bus.done);
    end
    tick();
    vec++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscmp++;
      $display("FAIL b2b_idle: v%b b%b want 0 0",
               bus.valid, bus.busy);
    end
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      vec++;
      if (bus.valid !== 1'b1 || bus.addr !== 4'(i)) begin
        miscmp++;
        $display("FAIL b2b_B_a%0d: v%b a%0d", i, bus.valid,
                 bus.addr);
      end
      tick();
    end
    vec++;
    if (bus.done !== 1'b1) begin
      miscmp++;
      $display("FAIL b2b_B_done: done=%b want 1", bus.done);
    end
    tick();
    tick();
    vec++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscmp++;
      $display("FAIL b2b_stop: v%b b%b want 0 0",
               bus.valid, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    bus.start = 1'b1;
    bus.ready = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    vec++;
    if (bus.addr !== 4'd7) begin
      miscmp++;
      $display("FAIL arst_pre: a%0d want 7", bus.addr);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({bus.valid, bus.last, bus.busy, bus.done} !== 4'b0 ||
        bus.addr !== 4'd0 || bus.col !== 2'd0 ||
        bus.row !== 2'd0) begin
      miscmp++;
      $display("FAIL arst_mid: v%b l%b b%b d%b a%0d want 0",
               bus.valid, bus.last, bus.busy, bus.done, bus.addr);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscmp++;
      $display("FAIL arst_idle: b%b d%b want 0 0",
               bus.busy, bus.done);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      vec++;
      if (bus.valid !== 1'b1 || bus.addr !== 4'(i)) begin
        miscmp++;
        $display("FAIL arst_frame_a%0d: v%b a%0d", i,
                 bus.valid, bus.addr);
      end
      tick();
    end
    vec++;
    if (bus.done !== 1'b1) begin
      miscmp++;
      $display("FAIL arst_done: done=%b want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_abort_last();
    bus.start = 1'b1;
    bus.ready = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (11) tick();
    vec++;
    if (bus.addr !== 4'd11 || bus.last !== 1'b1) begin
      miscmp++;
      $display("FAIL abl_pre: a%0d l%b want 11 1",
               bus.addr, bus.last);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    vec++;
    if (bus.done !== 1'b0 || bus.valid !== 1'b0 ||
        bus.busy !== 1'b0) begin
      miscmp++;
      $display("FAIL abl_post: d%b v%b b%b want 0 0 0",
               bus.done, bus.valid, bus.busy);
    end
    tick();
    vec++;
    if (bus.done !== 1'b0) begin
      miscmp++;
      $display("FAIL abl_nodone: done=%b want 0", bus.done);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_abort_last();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miscmp);
    $finish;
  end
endmodule
